// File: rtl/fiber_bus_master.sv
// Initiator for the fiber register bus: one strobe per command, waits for ACK or times out.
// Optional statistics counters are built only when FIBER_BUS_STATS_EN is defined.
`timescale 1ns/1ps

module fiber_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned STAT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic [1:0]        rsp_status_o,
  output logic [31:0]       fiber_bus_addr_o,
  output logic [31:0]       fiber_bus_dout_o,
  input  logic [31:0]       fiber_bus_din_i,
  output logic              fiber_bus_wr_o,
  output logic              fiber_bus_rd_o,
  input  logic              fiber_bus_ack_i,
  output logic [STAT_W-1:0] stat_xfer_o,
  output logic [STAT_W-1:0] stat_tmo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_DATA = 32'hDEAD_DEAD;
  localparam logic [1:0]  ST_OK    = 2'b00;
  localparam logic [1:0]  ST_TMO   = 2'b01;

  state_e      state_q;
  logic [15:0] tmoCnt_q;
  logic [15:0] gapCnt_q;
  logic        isWrite_q;
  logic [31:0] addr_q;
  logic [31:0] dout_q;
  logic        wr_q;
  logic        rd_q;
  logic        rspValid_q;
  logic [31:0] rspData_q;
  logic [1:0]  rspStatus_q;

  logic        xferDone;
  logic        tmoDone;

  // ACK wins over a timeout that expires in the same cycle.
  assign xferDone = (state_q == ISSUE) && fiber_bus_ack_i;
  assign tmoDone  = (state_q == ISSUE) && !fiber_bus_ack_i && (tmoCnt_q == TMO_LAST);

  assign cmd_ready_o = (state_q == IDLE) && enable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      tmoCnt_q    <= '0;
      gapCnt_q    <= '0;
      isWrite_q   <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      rspStatus_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            addr_q    <= cmd_addr_i;
            dout_q    <= cmd_wdata_i;
            isWrite_q <= cmd_write_i;
            wr_q      <= cmd_write_i;
            rd_q      <= !cmd_write_i;
            tmoCnt_q  <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (xferDone) begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rspData_q   <= isWrite_q ? dout_q : fiber_bus_din_i;
            rspStatus_q <= ST_OK;
            rspValid_q  <= 1'b1;
            state_q     <= RESP;
          end else if (tmoDone) begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rspData_q   <= TMO_DATA;
            rspStatus_q <= ST_TMO;
            rspValid_q  <= 1'b1;
            state_q     <= RESP;
          end else begin
            tmoCnt_q <= tmoCnt_q + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rspValid_q <= 1'b0;
            gapCnt_q   <= '0;
            state_q    <= GAP;
          end
        end
        GAP: begin
          // The responder edge-detects the strobes, so they must rest low before the next command.
          if (gapCnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fiber_bus_addr_o = addr_q;
  assign fiber_bus_dout_o = dout_q;
  assign fiber_bus_wr_o   = wr_q;
  assign fiber_bus_rd_o   = rd_q;
  assign rsp_valid_o      = rspValid_q;
  assign rsp_data_o       = rspData_q;
  assign rsp_status_o     = rspStatus_q;

`ifdef FIBER_BUS_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] statXfer_q;
  logic [STAT_W-1:0] statXfer_d;
  logic [STAT_W-1:0] statTmo_q;
  logic [STAT_W-1:0] statTmo_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    statXfer_d = statXfer_q;
    statTmo_d  = statTmo_q;
    if (xferDone && (statXfer_q != '1)) begin
      statXfer_d = statXfer_q + STAT_ONE;
    end
    if (tmoDone && (statTmo_q != '1)) begin
      statTmo_d = statTmo_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      statXfer_q <= '0;
      statTmo_q  <= '0;
    end else begin
      statXfer_q <= statXfer_d;
      statTmo_q  <= statTmo_d;
    end
  end

  assign stat_xfer_o = statXfer_q;
  assign stat_tmo_o  = statTmo_q;
`else
  assign stat_xfer_o = '0;
  assign stat_tmo_o  = '0;
`endif

endmodule

// File: tb/tb_fiber_bus_master.sv
// Scoreboard bench for fiber_bus_master: randomized commands against an edge-detecting responder model.
// Stats expectations follow FIBER_BUS_STATS_EN when the bench is built with it.
`timescale 1ns/1ps

module tb_fiber_bus_master;

  localparam int TMO = 8;
  localparam int GAP = 2;
  localparam int SW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cmdValid;
  logic          cmdReady;
  logic          cmdWrite;
  logic [31:0]   cmdAddr;
  logic [31:0]   cmdWdata;
  logic          rspValid;
  logic          rspReady = 1'b0;
  logic [31:0]   rspData;
  logic [1:0]    rspStatus;
  logic [31:0]   busAddr;
  logic [31:0]   busDout;
  logic [31:0]   busDin = '0;
  logic          busWr;
  logic          busRd;
  logic          busAck = 1'b0;
  logic [SW-1:0] statXfer;
  logic [SW-1:0] statTmo;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          ackDelay;
  } plan_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  status;
    int          lat;
  } exp_t;

  plan_t planQ[$];
  exp_t  expQ[$];
  int    modelOk    = 0;
  int    modelTmo   = 0;
  int    holdLow    = 0;
  bit    abortXfer  = 1'b0;
  bit    randEnable = 1'b0;

  fiber_bus_master #(
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES    (GAP),
    .STAT_W        (SW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .cmd_valid_i     (cmdValid),
    .cmd_ready_o     (cmdReady),
    .cmd_write_i     (cmdWrite),
    .cmd_addr_i      (cmdAddr),
    .cmd_wdata_i     (cmdWdata),
    .rsp_valid_o     (rspValid),
    .rsp_ready_i     (rspReady),
    .rsp_data_o      (rspData),
    .rsp_status_o    (rspStatus),
    .fiber_bus_addr_o(busAddr),
    .fiber_bus_dout_o(busDout),
    .fiber_bus_din_i (busDin),
    .fiber_bus_wr_o  (busWr),
    .fiber_bus_rd_o  (busRd),
    .fiber_bus_ack_i (busAck),
    .stat_xfer_o     (statXfer),
    .stat_tmo_o      (statTmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A command is acknowledged only if the responder answers while the strobe is still up.
  function automatic bit acked(plan_t p);
    return (p.ackDelay >= 1) && (p.ackDelay <= TMO);
  endfunction

  function automatic exp_t predict(plan_t p);
    exp_t e;
    if (acked(p)) begin
      e.data   = p.write ? p.wdata : p.din;
      e.status = 2'b00;
      e.lat    = p.ackDelay + 1;
    end else begin
      e.data   = 32'hDEAD_DEAD;
      e.status = 2'b01;
      e.lat    = TMO + 1;
    end
    return e;
  endfunction

  function automatic int strobeLen(plan_t p);
    return acked(p) ? p.ackDelay : TMO;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] din, input int ackDelay);
    plan_t p;
    bit    accepted;
    p.write    = write;
    p.addr     = addr;
    p.wdata    = wdata;
    p.din      = din;
    p.ackDelay = ackDelay;
    planQ.push_back(p);
    expQ.push_back(predict(p));
    if (acked(p)) modelOk++;
    else modelTmo++;
    cmdValid = 1'b1;
    cmdWrite = write;
    cmdAddr  = addr;
    cmdWdata = wdata;
    accepted = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cmdReady) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    cmdAddr  = $urandom;
    cmdWdata = $urandom;
    checkOutput("cmd_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000; n++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_pending", expQ.size(), 32'd0);
    repeat (GAP + 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edge-detecting responder: ACKs in the planned strobe cycle, also drives stray ACKs while idle.
  initial begin
    plan_t cur;
    int    k;
    bit    prevStrobe;
    bit    strobe;
    cur.ackDelay = 0;
    k            = 0;
    prevStrobe   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      strobe = busWr || busRd;
      busAck = 1'b0;
      busDin = $urandom;
      if (strobe && !prevStrobe) begin
        if (planQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL strobe_unplanned: got strobe want none");
        end else begin
          cur = planQ.pop_front();
        end
        k = 1;
      end else if (strobe) begin
        k++;
      end
      if (strobe) begin
        checkOutput("strobe_wr", {31'd0, busWr}, {31'd0, cur.write});
        checkOutput("bus_addr", busAddr, cur.addr);
        checkOutput("bus_dout", busDout, cur.wdata);
      end
      if (strobe && (k == cur.ackDelay)) begin
        busAck = 1'b1;
        busDin = cur.din;
      end else if (!strobe && ($urandom_range(0, 7) == 0)) begin
        busAck = 1'b1;
      end
      if (!strobe && prevStrobe && !abortXfer) begin
        checkOutput("strobe_len", k, strobeLen(cur));
      end
      prevStrobe = strobe;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (holdLow > 0) begin
        rspReady = 1'b0;
        holdLow--;
      end else begin
        rspReady = ($urandom_range(0, 3) != 0);
      end
      if (randEnable) enable = ($urandom_range(0, 4) != 0);
    end
  end

  // Monitor: pops the scoreboard on each response handshake and polices bus-level rules.
  initial begin
    exp_t e;
    bit   prevValid;
    bit   prevReady;
    int   acceptCyc;
    int   lastRspCyc;
    prevValid  = 1'b0;
    prevReady  = 1'b0;
    acceptCyc  = 0;
    lastRspCyc = -100;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid  = 1'b0;
        lastRspCyc = -100;
      end else begin
        checkOutput("wr_rd_exclusive", {31'd0, busWr & busRd}, 32'd0);
        if (!enable || busWr || busRd || rspValid) begin
          checkOutput("cmd_ready_blocked", {31'd0, cmdReady}, 32'd0);
        end
        if (cmdValid && cmdReady) begin
          checkOutput("gap_before_accept", {31'd0, (cyc - lastRspCyc) >= (GAP + 1)}, 32'd1);
          acceptCyc = cyc;
        end
        if (prevValid && !prevReady) begin
          checkOutput("rsp_held", {31'd0, rspValid}, 32'd1);
        end
        if (rspValid && !prevValid && (expQ.size() > 0)) begin
          checkOutput("rsp_latency", cyc - acceptCyc, expQ[0].lat);
        end
        if (rspValid) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL rsp_unexpected: got data %h status %0d want no response", rspData, rspStatus);
          end else begin
            e = expQ[0];
            checkOutput("rsp_data", rspData, e.data);
            checkOutput("rsp_status", {30'd0, rspStatus}, {30'd0, e.status});
            if (rspReady) begin
              expQ.delete(0);
              lastRspCyc = cyc;
            end
          end
        end
        prevValid = rspValid;
        prevReady = rspReady;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    cmdValid = 1'b0;
    cmdWrite = 1'b0;
    cmdAddr  = '0;
    cmdWdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_addr", busAddr, 32'd0);
    checkOutput("reset_dout", busDout, 32'd0);
    checkOutput("reset_rsp_data", rspData, 32'd0);
    checkOutput("reset_rsp_status", {30'd0, rspStatus}, 32'd0);
    checkOutput("reset_wr", {31'd0, busWr}, 32'd0);
    checkOutput("reset_rd", {31'd0, busRd}, 32'd0);
    checkOutput("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("reset_stat_xfer", {16'd0, statXfer}, 32'd0);
    checkOutput("reset_stat_tmo", {16'd0, statTmo}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cmdValid = 1'b1;
    @(negedge clk);
    checkOutput("ready_when_disabled", {31'd0, cmdReady}, 32'd0);
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    enable   = 1'b1;

    applyStimulus(1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0000_0000, 3);
    applyStimulus(1'b0, 32'h0000_0200, 32'hA5A5_A5A5, 32'hCAFE_F00D, 3);
    applyStimulus(1'b0, 32'h0000_0300, 32'h0000_0000, 32'h1111_2222, 0);
    applyStimulus(1'b1, 32'h0000_0304, 32'h0BAD_F00D, 32'h0000_0000, TMO);
    holdLow = 12;
    applyStimulus(1'b1, 32'h0000_0400, 32'h1111_1111, 32'h0000_0000, 3);
    applyStimulus(1'b1, 32'h0000_0404, 32'h2222_2222, 32'h0000_0000, 2);
    drain();

    // Reset while a read waits on a dead target: the command must vanish without a response.
    applyStimulus(1'b0, 32'h0000_0500, 32'h0000_0000, 32'h0000_0000, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    abortXfer = 1'b1;
    rst       = 1'b1;
    expQ.delete(expQ.size() - 1);
    modelOk  = 0;
    modelTmo = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_wr", {31'd0, busWr}, 32'd0);
    checkOutput("midreset_rd", {31'd0, busRd}, 32'd0);
    checkOutput("midreset_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("midreset_ready_idle", {31'd0, cmdReady}, 32'd1);
    enable = 1'b0;
    #1;
    checkOutput("midreset_ready_disabled", {31'd0, cmdReady}, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    repeat (TMO + 4) begin
      @(posedge clk);
      #1;
    end
    abortXfer = 1'b0;

    randEnable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                    int'($urandom_range(0, TMO + 2)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    randEnable = 1'b0;
    enable     = 1'b1;
    drain();

`ifdef FIBER_BUS_STATS_EN
    checkOutput("stat_xfer", {16'd0, statXfer}, modelOk);
    checkOutput("stat_tmo", {16'd0, statTmo}, modelTmo);
`else
    checkOutput("stat_xfer", {16'd0, statXfer}, 32'd0);
    checkOutput("stat_tmo", {16'd0, statTmo}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
